// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, entry FSM states and key classification helpers
package keypad_pkg;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} entry_state_t;
  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction
  function automatic logic is_cmd(input logic [3:0] k);
    return k >= KEY_A && k <= KEY_D;
  endfunction
endpackage

// File: rtl/keypad_entry_buffer_key_event_detect.sv
// key_event_detect: turns the scanner's key_valid level into a one-cycle event with the captured code
module key_event_detect (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  output logic       evt_o,
  output logic [3:0] key_code_o
);
  logic       kv_q;
  logic       evt_q;
  logic [3:0] code_q;
  // scanner shares clk, so the level is registered directly; rising edge becomes the event
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kv_q   <= 1'b0;
      evt_q  <= 1'b0;
      code_q <= 4'h0;
    end else begin
      kv_q   <= key_valid_i;
      evt_q  <= key_valid_i & ~kv_q;
      code_q <= key_code_i;
    end
  end
  assign evt_o      = evt_q;
  assign key_code_o = code_q;
endmodule

// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: accumulates keypad digits into a BCD entry with backspace, commit handshake, commands and timeout
import keypad_pkg::*;
module keypad_entry_buffer #(
  parameter int          NUM_DIGITS  = 4,
  parameter int unsigned TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [3:0]                        key_code_i,
  input  logic                              key_valid_i,
  output logic [4*NUM_DIGITS-1:0]           digits_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count_o,
  output logic [4*NUM_DIGITS-1:0]           value_o,
  output logic                              value_valid_o,
  input  logic                              value_ready_i,
  output logic [1:0]                        cmd_code_o,
  output logic                              cmd_valid_o,
  output logic                              overflow_err_o,
  output logic                              timeout_evt_o
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int NW = $clog2(NUM_DIGITS + 1);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [NW-1:0] FULL = NW'(NUM_DIGITS);
  localparam logic [CW-1:0] IDLE_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  logic         evt;
  logic [3:0]   code;
  entry_state_t state_q, state_d;
  logic [DW-1:0] digits_q, digits_d, value_q, value_d;
  logic [NW-1:0] count_q, count_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [1:0]    cmd_code_q, cmd_code_d;
  logic          vvalid_q, vvalid_d, cmd_valid_q, cmd_valid_d, ovf_q, ovf_d, tmo_q, tmo_d;
  key_event_detect u_det (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .key_valid_i(key_valid_i),
    .key_code_i (key_code_i),
    .evt_o      (evt),
    .key_code_o (code)
  );
  // state, entry buffer, idle counter and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      count_q     <= '0;
      value_q     <= '0;
      vvalid_q    <= 1'b0;
      idle_q      <= '0;
      cmd_code_q  <= 2'd0;
      cmd_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      count_q     <= count_d;
      value_q     <= value_d;
      vvalid_q    <= vvalid_d;
      idle_q      <= idle_d;
      cmd_code_q  <= cmd_code_d;
      cmd_valid_q <= cmd_valid_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
    end
  end
  // key handling, commit handshake and inactivity timeout; an event always beats an expiring timeout
  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    count_d     = count_q;
    value_d     = value_q;
    vvalid_d    = vvalid_q;
    cmd_code_d  = cmd_code_q;
    cmd_valid_d = 1'b0;
    ovf_d       = 1'b0;
    tmo_d       = 1'b0;
    idle_d      = '0;
    case (state_q)
      HOLD: begin
        if (value_ready_i) begin
          vvalid_d = 1'b0;
          digits_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        if (evt) begin
          if (is_digit(code)) begin
            if (count_q == FULL) begin
              ovf_d = 1'b1;
            end else begin
              digits_d = (digits_q << 4) | DW'(code);
              count_d  = count_q + 1'b1;
              state_d  = ENTRY;
            end
          end else if (is_cmd(code)) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = 2'(code - KEY_A);
          end else if (state_q == ENTRY && code == KEY_STAR) begin
            digits_d = digits_q >> 4;
            count_d  = count_q - 1'b1;
            state_d  = (count_q == NW'(1)) ? IDLE : ENTRY;
          end else if (state_q == ENTRY && code == KEY_HASH) begin
            value_d  = digits_q;
            vvalid_d = 1'b1;
            state_d  = HOLD;
          end
        end else if (state_q == ENTRY && TIMEOUT_CYC != 0) begin
          if (idle_q == IDLE_LAST) begin
            digits_d = '0;
            count_d  = '0;
            state_d  = IDLE;
            tmo_d    = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
    endcase
  end
  assign digits_o       = digits_q;
  assign digit_count_o  = count_q;
  assign value_o        = value_q;
  assign value_valid_o  = vvalid_q;
  assign cmd_code_o     = cmd_code_q;
  assign cmd_valid_o    = cmd_valid_q;
  assign overflow_err_o = ovf_q;
  assign timeout_evt_o  = tmo_q;
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// tb_keypad_entry_buffer: table-driven key presses with a scoreboard queue plus handshake, timeout and reset sequences
module tb_keypad_entry_buffer;
  typedef struct {
    logic [3:0]  key;
    logic [15:0] dig;
    logic [2:0]  cnt;
    logic        cv;
    logic [1:0]  cc;
    logic        ov;
    logic        vv;
    logic [15:0] val;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_valid = 1'b0;
  logic        value_ready = 1'b0;
  logic [15:0] digits, value;
  logic [2:0]  count;
  logic [1:0]  cmd_code;
  logic        value_valid, cmd_valid, ovf, tmo;
  int checks = 0;
  int errors = 0;
  vec_t tbl[25];
  vec_t sb[$];
  keypad_entry_buffer #(.NUM_DIGITS(4), .TIMEOUT_CYC(20)) dut (
    .clk_i(clk), .rst_ni(rst_n), .key_code_i(key_code), .key_valid_i(key_valid),
    .digits_o(digits), .digit_count_o(count), .value_o(value), .value_valid_o(value_valid),
    .value_ready_i(value_ready), .cmd_code_o(cmd_code), .cmd_valid_o(cmd_valid),
    .overflow_err_o(ovf), .timeout_evt_o(tmo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic press(input vec_t v);
    vec_t e;
    @(negedge clk);
    key_code = v.key;
    key_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("digits k%0h", e.key), 32'(digits), 32'(e.dig));
    chk($sformatf("count k%0h", e.key), 32'(count), 32'(e.cnt));
    chk($sformatf("cmd_valid k%0h", e.key), 32'(cmd_valid), 32'(e.cv));
    if (e.cv) chk($sformatf("cmd_code k%0h", e.key), 32'(cmd_code), 32'(e.cc));
    chk($sformatf("overflow k%0h", e.key), 32'(ovf), 32'(e.ov));
    chk($sformatf("timeout k%0h", e.key), 32'(tmo), 32'h0);
    chk($sformatf("value_valid k%0h", e.key), 32'(value_valid), 32'(e.vv));
    if (e.vv) chk($sformatf("value k%0h", e.key), 32'(value), 32'(e.val));
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("held digits k%0h", e.key), 32'(digits), 32'(e.dig));
    chk($sformatf("held pulses k%0h", e.key), 32'({cmd_valid, ovf}), 32'h0);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask
  initial begin
    int n;
    bit found;
    tbl[0]  = '{4'h1, 16'h0001, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[1]  = '{4'h2, 16'h0012, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[2]  = '{4'h3, 16'h0123, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[3]  = '{4'h4, 16'h1234, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[4]  = '{4'h5, 16'h1234, 3'd4, 1'b0, 2'd0, 1'b1, 1'b0, 16'h0};
    tbl[5]  = '{4'hE, 16'h0123, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[6]  = '{4'hE, 16'h0012, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[7]  = '{4'hE, 16'h0001, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[8]  = '{4'hE, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[9]  = '{4'h4, 16'h0004, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[10] = '{4'h2, 16'h0042, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[11] = '{4'hE, 16'h0004, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[12] = '{4'hE, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[13] = '{4'hE, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[14] = '{4'h9, 16'h0009, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[15] = '{4'h8, 16'h0098, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[16] = '{4'hF, 16'h0098, 3'd2, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0098};
    tbl[17] = '{4'h7, 16'h0098, 3'd2, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0098};
    tbl[18] = '{4'hF, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[19] = '{4'hC, 16'h0000, 3'd0, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0};
    tbl[20] = '{4'h6, 16'h0006, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[21] = '{4'hC, 16'h0006, 3'd1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0};
    tbl[22] = '{4'hA, 16'h0006, 3'd1, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0};
    tbl[23] = '{4'hD, 16'h0006, 3'd1, 1'b1, 2'd3, 1'b0, 1'b0, 16'h0};
    tbl[24] = '{4'hE, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {digits, value, 3'(count), value_valid, cmd_valid, ovf, tmo}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) press(tbl[i]);
    repeat (10) @(posedge clk);
    #1;
    chk("hold valid", 32'(value_valid), 32'h1);
    chk("hold value", 32'(value), 32'h0098);
    @(negedge clk);
    value_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("accept valid", 32'(value_valid), 32'h0);
    chk("accept count", 32'(count), 32'h0);
    chk("accept digits", 32'(digits), 32'h0);
    @(negedge clk);
    value_ready = 1'b0;
    for (int i = 18; i < 25; i++) press(tbl[i]);
    @(negedge clk);
    key_code = 4'h5;
    key_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("timeout start count", 32'(count), 32'h1);
    key_valid = 1'b0;
    found = 1'b0;
    n = 0;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(posedge clk);
      #1;
      if (tmo) begin
        found = 1'b1;
        n = c;
      end
    end
    chk("timeout cycles", 32'(n), 32'd20);
    chk("timeout digits", 32'(digits), 32'h0);
    chk("timeout count", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    chk("timeout one pulse", 32'(tmo), 32'h0);
    press('{4'h3, 16'h0003, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0});
    press('{4'hF, 16'h0003, 3'd1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0003});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset mid-hold", {digits, value, 3'(count), value_valid, cmd_valid, ovf, tmo}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Accumulates key codes from the 4x4 matrix keypad scanner into a multi-digit BCD entry, sitting directly downstream of the scanner's `bcd_out`/`key_valid` outputs. It provides:
- a live digit register for the display driver;
- backspace (`*`), commit (`#`) and command keys (`A`–`D`);
- an inactivity timeout;
- a valid/ready handshake that hands the committed number to the consumer.

## Interface
- `NUM_DIGITS`, 4: digit capacity of the entry buffer (≥1).
- `TIMEOUT_CYC`, 24'd5_000_000: idle cycles before a partial entry is discarded; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `key_code`  in  4  key code from the scanner (0–9 digits, A–D commands, E = `*`, F = `#`).
- `key_valid`  in  1  scanner key-valid level; only its rising edge counts as an event.
- `digits_out`  out  4*NUM_DIGITS  current entry; newest digit in nibble 0; unused nibbles 0.
- `digit_count`  out  $clog2(NUM_DIGITS+1)  number of digits entered.
- `value_out`  out  4*NUM_DIGITS  committed entry; stable while `value_valid` is high.
- `value_valid`  out  1  committed value available.
- `value_ready`  in  1  consumer accepts the value.
- `cmd_code`  out  2  command index (A=0, B=1, C=2, D=3).
- `cmd_valid`  out  1  one-cycle command strobe.
- `overflow_err`  out  1  one-cycle pulse: digit dropped because the buffer is full.
- `timeout_evt`  out  1  one-cycle pulse: entry discarded by the timeout.

## Operation
- **Event detection**: `key_valid` is registered.
  - An event is the cycle where `key_valid`=1 and the registered copy is 0.
  - `key_code` is captured in the same cycle.
  - A held level produces exactly one event.
- **States**: IDLE (count 0), ENTRY (count ≥1), HOLD (committed value awaiting acceptance).
- **Digit 0–9**:
  - In IDLE or ENTRY with count < NUM_DIGITS: `digits_out` ← (`digits_out` << 4) | digit, count+1, state ENTRY.
  - In IDLE or ENTRY with count = NUM_DIGITS: buffer unchanged, `overflow_err` pulse.
- **`*` (E)**:
  - In ENTRY: `digits_out` >> 4, count−1; state IDLE when count reaches 0.
  - In IDLE: no effect.
- **`#` (F)**:
  - In ENTRY: `value_out` ← `digits_out`, `value_valid` ← 1, state HOLD.
  - In IDLE: ignored, no `value_valid`.
- **A–D**:
  - In IDLE or ENTRY: `cmd_valid` pulse with `cmd_code` = key−0xA; buffer unchanged.
- **HOLD**:
  - All key events are dropped with no error pulse.
  - `value_valid` stays high and `value_out` stays frozen until a clock edge with `value_ready`=1.
  - On that edge: `value_valid` ← 0, buffer and count cleared, state IDLE.
- **Timeout**:
  - The idle counter clears on every event and counts in ENTRY only.
  - When it reaches TIMEOUT_CYC−1: buffer cleared, count 0, state IDLE, `timeout_evt` pulse.
  - The counter is held at 0 in IDLE and HOLD.
- **Simultaneous event and timeout expiry**: the event wins and the counter clears.
- **Reset values**: all outputs 0, state IDLE, counters 0, edge register 0. Reset mid-HOLD drops the pending value with no handshake.

## Timing
- Event at edge t (`key_valid` sampled 1 at t, 0 at t−1) → `digits_out`, `digit_count`, `cmd_valid` and `overflow_err` update at edge t+1.
- Commit: `value_valid` is high from edge t+1.
- Acceptance: with `value_ready`=1 sampled at edge r, `value_valid` is low and the buffer is cleared after edge r. `value_ready` already high at t+1 completes the transfer in one cycle.
- `value_valid` does not depend combinationally on `value_ready`.
- `cmd_valid`, `overflow_err` and `timeout_evt` are high for exactly one cycle.
- Minimum spacing between events is 2 cycles, set by the edge detector.

## Structure
- Package `keypad_pkg`:
  - key code constants `KEY_STAR`=4'hE, `KEY_HASH`=4'hF, `KEY_A`..`KEY_D`;
  - the `entry_state_t` enum {IDLE, ENTRY, HOLD}.
- Sub-module `key_event_detect`: registers `key_valid`, outputs a one-cycle `evt` and the captured `key_code`. No synchronizer is needed because the scanner shares `clk`.
- The top level holds the FSM, the shift register, the idle counter (width $clog2(TIMEOUT_CYC+1)) and the output registers.

## Test plan
- **Digit entry**: keys 1,2,3 (`key_valid` held 5 cycles each) → `digits_out`=16'h0123, count 3; a single event per press.
- **Overflow**: keys 1,2,3,4,5 → `digits_out`=16'h1234, `overflow_err` pulses once on key 5.
- **Backspace and IDLE**: 4,2,`*`,`*`,`*` → 16'h0042, 16'h0004, 16'h0000 with state IDLE; the third `*` has no effect.
- **Commit with back-pressure**:
  - 9,8,`#` with `value_ready`=0 for 10 cycles → `value_valid` high with `value_out`=16'h0098; a digit 7 pressed during HOLD is dropped.
  - `value_ready`=1 → `value_valid` low next cycle, count 0.
- **Empty commit and commands**: `#` in IDLE → no `value_valid`. Key C → `cmd_valid` one cycle with `cmd_code`=2; buffer unchanged.
- **Timeout and reset**:
  - TIMEOUT_CYC=20, key 5, then no input → `timeout_evt` 20 cycles after the event, buffer cleared.
  - `rst` asserted low mid-HOLD → all outputs 0 immediately.
